// File: rtl/vec_alu_pkg.sv
// Shared constants and helpers for the multi-lane vector integer ALU.
// Opcode/op_type encodings and the chunk-width rule live here so the top and lanes agree.
package vec_alu_pkg;

  localparam logic [5:0] VADD = 6'b000000;
  localparam logic [5:0] VAND = 6'b001001;
  localparam logic [5:0] VOR  = 6'b001010;
  localparam logic [5:0] VXOR = 6'b001011;

  localparam logic [2:0] OPT_VV = 3'b001;
  localparam logic [2:0] OPT_VX = 3'b010;
  localparam logic [2:0] OPT_VI = 3'b100;

  // log2 of the chunk width: the element width, capped at the lane datapath width.
  function automatic logic [2:0] chunk_log2(input logic [2:0] vsew, input int lane_width);
    logic [2:0] cap;
    cap = 3'(lane_width - 3);
    return (vsew < cap ? vsew : cap) + 3'd3;
  endfunction

endpackage

// File: rtl/vec_alu_lane.sv
// One ALU lane: operates on a chunk of up to 2**LANE_WIDTH bits, with carry
// in/out so that several chunks can form one wider element.
module vec_alu_lane
  import vec_alu_pkg::*;
#(
  parameter int LANE_WIDTH = 4
) (
  input  logic [(1<<LANE_WIDTH)-1:0] a,
  input  logic [(1<<LANE_WIDTH)-1:0] b,
  input  logic [5:0]                 opcode,
  input  logic [2:0]                 w_log,
  input  logic                       carry_in,
  input  logic                       sew_boundary,
  output logic [(1<<LANE_WIDTH)-1:0] result,
  output logic                       carry_out
);

  localparam int LWB = 1 << LANE_WIDTH;

  logic [6:0]   w_bits;
  logic [LWB:0] cbit;
  logic [LWB-1:0] mask;
  logic [LWB:0] sum;
  logic         cin_eff;

  // cbit marks the bit just above the active chunk; the carry out is read from there.
  assign w_bits = 7'd1 << w_log;
  assign cbit   = (LWB+1)'(1) << w_bits;
  assign mask   = cbit[LWB-1:0] - LWB'(1);

  assign cin_eff = carry_in & ~sew_boundary;
  assign sum     = {1'b0, a & mask} + {1'b0, b & mask} + (LWB+1)'(cin_eff);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    result    = '0;
    carry_out = 1'b0;
    case (opcode)
      VADD: begin
        result    = sum[LWB-1:0] & mask;
        carry_out = |(sum & cbit);
      end
      VAND:    result = a & b & mask;
      VOR:     result = (a | b) & mask;
      VXOR:    result = (a ^ b) & mask;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/vec_alu_lane_wrapper.sv
// Multi-lane vector ALU: walks a VLEN-bit operation in chunks across 1, 2 or 4 lanes,
// emitting one registered chunk and its bit offset per lane per step.
module vec_alu_lane_wrapper
  import vec_alu_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int LANE_WIDTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [1:0]      nb_lanes,
  input  logic [5:0]      opcode,
  input  logic            run0,
  input  logic            run1,
  input  logic            run2,
  input  logic            run3,
  input  logic [VLEN-1:0] vs1,
  input  logic [VLEN-1:0] vs2,
  input  logic [2:0]      vsew,
  input  logic [2:0]      op_type,
  output logic [63:0]     vd0,
  output logic [63:0]     vd1,
  output logic [63:0]     vd2,
  output logic [63:0]     vd3,
  output logic [9:0]      regi0,
  output logic [9:0]      regi1,
  output logic [9:0]      regi2,
  output logic [9:0]      regi3,
  output logic            done_out
);

  localparam int LWB = 1 << LANE_WIDTH;
  localparam int KW  = 16;

  logic [2:0]    w_log;
  logic [2:0]    cpe_log;
  logic [KW-1:0] cpe_mask;
  logic [KW-1:0] nb_chunks;
  logic [KW-1:0] nb_steps;
  logic [KW-1:0] last_step;
  logic          is_scalar;
  logic [3:0]    run;
  logic [3:0]    lane_en;
  logic          carry_last;

  logic [KW-1:0]  step_q;
  logic           carry_q;
  logic           done_q;
  logic [63:0]    vd_q   [4];
  logic [9:0]     regi_q [4];

  logic [KW-1:0]  chunk_idx [4];
  logic [KW-1:0]  a_off     [4];
  logic [KW-1:0]  b_off     [4];
  logic [LWB-1:0] a_op      [4];
  logic [LWB-1:0] b_op      [4];
  logic [LWB-1:0] res       [4];
  logic           boundary  [4];
  logic           cin       [4];
  logic           cout      [4];

  assign w_log     = chunk_log2(vsew, LANE_WIDTH);
  assign cpe_log   = vsew - (w_log - 3'd3);
  assign cpe_mask  = (KW'(1) << cpe_log) - KW'(1);
  assign nb_chunks = KW'(VLEN) >> w_log;
  assign nb_steps  = nb_chunks >> nb_lanes;
  assign last_step = nb_steps - KW'(1);
  // Unknown op_type encodings fall back to VV.
  assign is_scalar = (op_type == OPT_VX) || (op_type == OPT_VI);
  assign run       = {run3, run2, run1, run0};

  always_comb begin
    lane_en    = 4'b1111;
    carry_last = cout[3];
    case (nb_lanes)
      2'd0: begin
        lane_en    = 4'b0001;
        carry_last = cout[0];
      end
      2'd1: begin
        lane_en    = 4'b0011;
        carry_last = cout[1];
      end
      default: begin
        lane_en    = 4'b1111;
        carry_last = cout[3];
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign chunk_idx[gi] = (step_q << nb_lanes) + KW'(gi);
    assign a_off[gi]     = chunk_idx[gi] << w_log;
    // Scalar forms broadcast the element-0 chunk of vs1 to every element.
    assign b_off[gi]     = is_scalar ? ((chunk_idx[gi] & cpe_mask) << w_log) : a_off[gi];
    assign a_op[gi]      = LWB'(vs2 >> a_off[gi]);
    assign b_op[gi]      = LWB'(vs1 >> b_off[gi]);
    assign boundary[gi]  = (chunk_idx[gi] & cpe_mask) == '0;

    if (gi == 0) begin : g_cin_reg
      assign cin[gi] = carry_q;
    end else begin : g_cin_chain
      assign cin[gi] = cout[gi-1];
    end

    vec_alu_lane #(.LANE_WIDTH(LANE_WIDTH)) u_lane (
      .a            (a_op[gi]),
      .b            (b_op[gi]),
      .opcode       (opcode),
      .w_log        (w_log),
      .carry_in     (cin[gi]),
      .sew_boundary (boundary[gi]),
      .result       (res[gi]),
      .carry_out    (cout[gi])
    );
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (resetn) begin
      step_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      // NOTE: these four result registers are plain flops, not a RAM, so they are cleared on reset.
      for (int i = 0; i < 4; i++) begin
        vd_q[i]   <= '0;
        regi_q[i] <= '0;
      end
    end else if (!run0) begin
      step_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (!done_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i] && run[i]) begin
          vd_q[i]   <= 64'(res[i]);
          regi_q[i] <= a_off[i][9:0];
        end
      end
      carry_q <= carry_last;
      step_q  <= step_q + KW'(1);
      if (step_q == last_step) done_q <= 1'b1;
    end
  end

  assign vd0      = vd_q[0];
  assign vd1      = vd_q[1];
  assign vd2      = vd_q[2];
  assign vd3      = vd_q[3];
  assign regi0    = regi_q[0];
  assign regi1    = regi_q[1];
  assign regi2    = regi_q[2];
  assign regi3    = regi_q[3];
  assign done_out = done_q;

endmodule

// File: tb/tb_vec_alu_lane_wrapper.sv
// Scoreboard bench for vec_alu_lane_wrapper: an element-wise reference model
// predicts each chunk; merged results are also checked against known vectors.
module tb_vec_alu_lane_wrapper;

  localparam int VLEN = 128;

  localparam logic [127:0] VS1 = 128'habcdabcdbeefbeef1234567887654321;
  localparam logic [127:0] VS2 = 128'h8765432112345678beefbeefabcdabcd;

  logic         clk;
  logic         resetn;
  logic [1:0]   nb_lanes;
  logic [5:0]   opcode;
  logic         run0, run1, run2, run3;
  logic [127:0] vs1, vs2;
  logic [2:0]   vsew;
  logic [2:0]   op_type;
  logic [63:0]  vd0, vd1, vd2, vd3;
  logic [9:0]   regi0, regi1, regi2, regi3;
  logic         done_out;

  int n_checks;
  int n_fail;

  typedef struct {
    int          lane;
    logic [9:0]  regi;
    logic [63:0] vd;
  } exp_t;

  exp_t sb[$];

  vec_alu_lane_wrapper #(.VLEN(VLEN), .LANE_WIDTH(4)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .nb_lanes (nb_lanes),
    .opcode   (opcode),
    .run0     (run0),
    .run1     (run1),
    .run2     (run2),
    .run3     (run3),
    .vs1      (vs1),
    .vs2      (vs2),
    .vsew     (vsew),
    .op_type  (op_type),
    .vd0      (vd0),
    .vd1      (vd1),
    .vd2      (vd2),
    .vd3      (vd3),
    .regi0    (regi0),
    .regi1    (regi1),
    .regi2    (regi2),
    .regi3    (regi3),
    .done_out (done_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] dut_vd(input int l);
    case (l)
      0: return vd0;
      1: return vd1;
      2: return vd2;
      default: return vd3;
    endcase
  endfunction

  function automatic logic [9:0] dut_regi(input int l);
    case (l)
      0: return regi0;
      1: return regi1;
      2: return regi2;
      default: return regi3;
    endcase
  endfunction

  // Whole-element reference: no chunking, no carry chain.
  function automatic logic [127:0] model(input logic [5:0] opc, input int sew,
                                         input logic [2:0] opt,
                                         input logic [127:0] s1, input logic [127:0] s2);
    int ew;
    logic [63:0]  m, a, b, r;
    logic [127:0] out;
    ew  = 8 << sew;
    m   = (ew == 64) ? {64{1'b1}} : ((64'd1 << ew) - 64'd1);
    out = '0;
    for (int e = 0; e < 128 / ew; e++) begin
      a = 64'(s2 >> (e * ew)) & m;
      b = (opt == 3'b010 || opt == 3'b100) ? (64'(s1) & m) : (64'(s1 >> (e * ew)) & m);
      case (opc)
        6'b000000: r = (a + b) & m;
        6'b001001: r = a & b;
        6'b001010: r = a | b;
        6'b001011: r = a ^ b;
        default:   r = '0;
      endcase
      out = out | (128'(r) << (e * ew));
    end
    return out;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    for (int l = 0; l < 4; l++) begin
      n_checks++;
      if (dut_vd(l) !== 64'd0 || dut_regi(l) !== 10'd0) begin
        n_fail++;
        $display("FAIL reset lane%0d: vd=%h regi=%0d, want 0/0", l, dut_vd(l), dut_regi(l));
      end
    end
    n_checks++;
    if (done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset done_out: got %b want 0", done_out);
    end
  endtask

  // Runs one operation start to finish, scoreboard-checking every chunk and done_out.
  task automatic run_op(input string name, input int sew, input int nb,
                        input logic [5:0] opc, input logic [2:0] opt,
                        input logic [127:0] s1, input logic [127:0] s2,
                        input logic [127:0] exp_merged);
    int w, n, steps;
    logic [127:0] ref_vd, merged, wmask;
    logic [63:0]  cmask, last0;
    exp_t e;
    w      = 8 << ((sew < 1) ? sew : 1);
    n      = 1 << nb;
    steps  = (VLEN / w) / n;
    cmask  = (64'd1 << w) - 64'd1;
    ref_vd = model(opc, sew, opt, s1, s2);
    merged = '0;
    last0  = '0;

    nb_lanes = 2'(nb); opcode = opc; op_type = opt; vsew = 3'(sew);
    vs1 = s1; vs2 = s2;
    run0 = 1'b0; run1 = 1'b1; run2 = 1'b1; run3 = 1'b1;
    tick();
    n_checks++;
    if (done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle done_out: got %b want 0", name, done_out);
    end

    run0 = 1'b1;
    for (int s = 0; s < steps; s++) begin
      for (int l = 0; l < n; l++) begin
        e.lane = l;
        e.regi = 10'((s * n + l) * w);
        e.vd   = 64'(ref_vd >> ((s * n + l) * w)) & cmask;
        sb.push_back(e);
      end
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        n_checks++;
        if (dut_vd(e.lane) !== e.vd || dut_regi(e.lane) !== e.regi) begin
          n_fail++;
          $display("FAIL %s step%0d lane%0d: vd=%h regi=%0d, want vd=%h regi=%0d",
                   name, s, e.lane, dut_vd(e.lane), dut_regi(e.lane), e.vd, e.regi);
        end
        wmask  = 128'(cmask) << e.regi;
        merged = (merged & ~wmask) | ((128'(dut_vd(e.lane)) & 128'(cmask)) << dut_regi(e.lane));
        if (e.lane == 0) last0 = e.vd;
      end
      n_checks++;
      if (done_out !== (s == steps - 1)) begin
        n_fail++;
        $display("FAIL %s done step%0d: got %b want %b", name, s, done_out, (s == steps - 1));
      end
    end

    n_checks++;
    if (merged !== exp_merged) begin
      n_fail++;
      $display("FAIL %s merged vd: got %h want %h", name, merged, exp_merged);
    end

    // Done must hold and lane 0 must not advance while run0 stays high.
    tick();
    n_checks++;
    if (done_out !== 1'b1 || vd0 !== last0) begin
      n_fail++;
      $display("FAIL %s hold: done=%b vd0=%h, want done=1 vd0=%h", name, done_out, vd0, last0);
    end
  endtask

  task automatic test_add_sew();
    run_op("add_sew0", 0, 0, 6'b000000, 3'b001, VS1, VS2, 128'h3232eeeed0231467d02314673232eeee);
    run_op("add_sew1", 1, 0, 6'b000000, 3'b001, VS1, VS2, 128'h3332eeeed1231567d12315673332eeee);
    run_op("add_sew2", 2, 0, 6'b000000, 3'b001, VS1, VS2, 128'h3332eeeed1241567d12415673332eeee);
    run_op("add_sew3", 3, 0, 6'b000000, 3'b001, VS1, VS2, 128'h3332eeeed1241567d12415683332eeee);
  endtask

  task automatic test_vx();
    run_op("add_vx", 0, 0, 6'b000000, 3'b010, 128'h1, VS2, 128'h8866442213355779bff0bff0acceacce);
  endtask

  task automatic test_logic();
    run_op("and_sew1", 1, 0, 6'b001001, 3'b001, VS1, VS2, VS1 & VS2);
    run_op("xor_sew1", 1, 0, 6'b001011, 3'b001, VS1, VS2, VS1 ^ VS2);
  endtask

  task automatic test_four_lanes();
    run_op("add_4lane", 0, 2, 6'b000000, 3'b001, VS1, VS2, 128'h3232eeeed0231467d02314673232eeee);
  endtask

  task automatic test_reset_mid_run();
    nb_lanes = 2'd2; opcode = 6'b000000; op_type = 3'b001; vsew = 3'd0;
    vs1 = VS1; vs2 = VS2;
    run0 = 1'b0;
    tick();
    run0 = 1'b1;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    run0   = 1'b0;
    for (int l = 0; l < 4; l++) begin
      n_checks++;
      if (dut_vd(l) !== 64'd0 || dut_regi(l) !== 10'd0) begin
        n_fail++;
        $display("FAIL midrun_reset lane%0d: vd=%h regi=%0d, want 0/0", l, dut_vd(l), dut_regi(l));
      end
    end
    n_checks++;
    if (done_out !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset done_out: got %b want 0", done_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    nb_lanes = 2'd0; opcode = 6'b000000; op_type = 3'b001; vsew = 3'd0;
    run0 = 1'b0; run1 = 1'b0; run2 = 1'b0; run3 = 1'b0;
    vs1 = '0; vs2 = '0;
    tick();
    test_reset();
    test_add_sew();
    test_vx();
    test_logic();
    test_four_lanes();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
